// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the CPU control FSM and data_mem.
// It takes one request, holds the address (and store data) stable on the memory
// port for the setup, wait and access cycles, captures load data, then pulses done.
// Optional feature macro: LSU_PROT_CHK_EN blocks stores at or above PROT_BASE
// and reports them through the fault pulse.
module lsu_mem_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int WAIT_CYC = 0,
  parameter logic [AW-1:0] PROT_BASE = 8'hF0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          store,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          fault,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          store_q;
  logic          prot_en;
  logic          blocked;

`ifdef LSU_PROT_CHK_EN
  assign prot_en = 1'b1;
`else
  assign prot_en = 1'b0;
`endif

  // A blocked store still walks the whole sequence; only its write strobe is suppressed.
  assign blocked = prot_en & store_q & (addr_q >= PROT_BASE);

  // Everything the memory and the control FSM see is decoded from registered state.
  assign ready    = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign fault    = (state == S_DONE) & blocked;
  assign mem_we   = (state == S_ACCESS) & store_q & ~blocked;
  assign mem_addr = addr_q;
  assign mem_wd   = wdata_q;

  // State, wait counter and request capture. Load data is taken from the memory at
  // the edge that closes ACCESS. On reset, rdata is cleared only if the controller is
  // already idle, so an interrupted access leaves the last load result intact while a
  // power-up reset held for two cycles still brings rdata to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      if (state == S_IDLE) begin
        rdata <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        store_q <= store;
      end
      if (state == S_ACCESS && !store_q) begin
        rdata <= mem_rd;
      end
    end
  end

  // Next-state sequencing: ADDR always lasts one cycle, then WAIT_CYC wait cycles
  // counted down to zero, then one ACCESS cycle and one DONE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (WAIT_CYC == 0) begin
          state_nxt = S_ACCESS;
        end else begin
          cnt_nxt   = 4'(WAIT_CYC - 1);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_ACCESS;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule
